// File: rtl/scemi_rs_adapter_pkg.sv
// scemi_rs_adapter_pkg
//   Shared constants and helpers for the SceMi pipe ready/valid adapter.
//   Field layout of the proxy words:
//     PIPE_OUT : [DATA_W] valid, [DATA_W-1:0] payload
//     PIPE_IN  : {credit[CREDIT_W-1:0], resp_valid, resp_data[DATA_W-1:0]}
package scemi_rs_adapter_pkg;

  // Width of the optional saturating drop counter.
  localparam int DROP_COUNT_W = 16;

  // Credit counter is one bit wider than the FIFO pointer so that the host
  // can tell "DEPTH dequeues" apart from "no dequeues" between two samples.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int pipe_out_valid_bit(input int data_w);
    return data_w;
  endfunction

  function automatic int pipe_in_valid_bit(input int data_w);
    return data_w;
  endfunction

  function automatic int pipe_in_credit_lsb(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int pipe_in_width(input int data_w, input int credit_w);
    return credit_w + 1 + data_w;
  endfunction

endpackage

// File: rtl/scemi_rs_fifo.sv
// scemi_rs_fifo
//   Synchronous FIFO with a registered head (no fall-through). A word
//   written at edge N is visible on data/!empty after edge N+1.
//   Ports:
//     clk, srst     : clock, synchronous active-high reset
//     enq, enq_data : write request and payload (ignored when full unless
//                     a dequeue happens in the same cycle)
//     deq           : consume head (ignored when empty)
//     full, empty   : occupancy flags (occupancy counts the head register)
//     data          : registered head of queue
module scemi_rs_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enq,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;   // entries still in the array
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic deq_ok, wr_en, load;

  assign deq_ok = deq && out_valid_q;
  assign full   = (mem_cnt_q + CNT_W'(out_valid_q)) == CNT_W'(DEPTH);
  assign empty  = !out_valid_q;
  assign data   = out_data_q;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign wr_en  = enq && (!full || deq_ok);
  // Refill the head register only from words written on earlier edges.
  assign load   = (mem_cnt_q != '0) && (!out_valid_q || deq_ok);

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    case ({wr_en, load})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= enq_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (load) begin
        out_data_q  <= mem[rd_ptr_q];
        out_valid_q <= 1'b1;
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
      end else if (deq_ok) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/scemi_pipe_rs_adapter.sv
// scemi_pipe_rs_adapter
//   Bridges a free-running SceMi register-style pipe proxy to valid/ready
//   DUT streams. Host words are buffered in a FIFO; dequeues advance a
//   wrapping credit counter reported back to the host in PIPE_IN together
//   with one-cycle response pulses.
//   Ports:
//     CLK, RST   : clock, synchronous active-high reset
//     PIPE_OUT   : proxy word {valid, payload}
//     PIPE_IN    : registered proxy word {credit, resp_valid, resp_data}
//     RX_*       : receive stream (FIFO head) towards the DUT
//     TX_*       : response stream from the DUT
//     OVERFLOW   : sticky flag, a valid host word was dropped
//     DROP_COUNT : saturating drop count (only with
//                  SCEMI_RS_ADAPTER_DROP_COUNT_EN defined)
module scemi_pipe_rs_adapter
  import scemi_rs_adapter_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 8,
  localparam int CREDIT_W = credit_width(DEPTH)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_W:0]            PIPE_OUT,
  output logic [CREDIT_W+DATA_W:0]   PIPE_IN,
  output logic [DATA_W-1:0]          RX_DATA,
  output logic                       RX_VALID,
  input  logic                       RX_READY,
  input  logic [DATA_W-1:0]          TX_DATA,
  input  logic                       TX_VALID,
  output logic                       TX_READY,
  output logic                       OVERFLOW
`ifdef SCEMI_RS_ADAPTER_DROP_COUNT_EN
  ,
  output logic [DROP_COUNT_W-1:0]    DROP_COUNT
`endif
);

  localparam int OUT_VLD     = pipe_out_valid_bit(DATA_W);
  localparam int IN_VLD      = pipe_in_valid_bit(DATA_W);
  localparam int IN_CRED_LSB = pipe_in_credit_lsb(DATA_W);
  localparam int PIPE_IN_W   = pipe_in_width(DATA_W, CREDIT_W);

  logic                fifo_full, fifo_empty;
  logic                host_valid, deq, drop, tx_accept;
  logic [CREDIT_W-1:0] credit_q;
  logic                overflow_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                tx_ready_q;
  logic [PIPE_IN_W-1:0] pipe_in_q, pipe_in_d;

  assign host_valid = PIPE_OUT[OUT_VLD];
  assign deq        = !fifo_empty && RX_READY;
  assign drop       = host_valid && fifo_full && !deq;
  assign tx_accept  = TX_VALID && tx_ready_q;

  scemi_rs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .srst     (RST),
    .enq      (host_valid),
    .enq_data (PIPE_OUT[DATA_W-1:0]),
    .deq      (deq),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .data     (RX_DATA)
  );

  assign RX_VALID = !fifo_empty;
  assign TX_READY = tx_ready_q;
  assign OVERFLOW = overflow_q;
  assign PIPE_IN  = pipe_in_q;

  // PIPE_IN is a second register stage over the state registers, so the
  // mid-cycle proxy sample never sees a combinational input path.
  always_comb begin
    pipe_in_d = '0;
    pipe_in_d[IN_CRED_LSB +: CREDIT_W] = credit_q;
    pipe_in_d[IN_VLD]                  = resp_valid_q;
    pipe_in_d[DATA_W-1:0]              = resp_data_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      credit_q     <= '0;
      overflow_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      tx_ready_q   <= 1'b0;
      pipe_in_q    <= '0;
    end else begin
      if (deq)  credit_q   <= credit_q + CREDIT_W'(1);
      if (drop) overflow_q <= 1'b1;
      // Response is a one-cycle pulse; payload is zeroed when idle.
      resp_valid_q <= tx_accept;
      resp_data_q  <= tx_accept ? TX_DATA : '0;
      tx_ready_q   <= 1'b1;
      pipe_in_q    <= pipe_in_d;
    end
  end

`ifdef SCEMI_RS_ADAPTER_DROP_COUNT_EN
  logic [DROP_COUNT_W-1:0] drop_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_COUNT_W'(1);
    end
  end

  assign DROP_COUNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_scemi_pipe_rs_adapter.sv
// tb_scemi_pipe_rs_adapter
//   Directed bench for scemi_pipe_rs_adapter (DATA_W=8, DEPTH=4, CREDIT_W=3)
//   with a queue-based reference model compared every cycle, plus literal
//   expectations at the interesting points. Honours
//   SCEMI_RS_ADAPTER_DROP_COUNT_EN when defined.
module tb_scemi_pipe_rs_adapter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW:0]   pipe_out = '0;
  logic [CW+DW:0] pipe_in;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          overflow;
`ifdef SCEMI_RS_ADAPTER_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  scemi_pipe_rs_adapter #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .PIPE_OUT (pipe_out),
    .PIPE_IN  (pipe_in),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid),
    .RX_READY (rx_ready),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (tx_ready),
    .OVERFLOW (overflow)
`ifdef SCEMI_RS_ADAPTER_DROP_COUNT_EN
    ,
    .DROP_COUNT (drop_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- reference model ----------------
  // A word pushed at edge t becomes visible at the head after a later edge.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  ent_t           q[$];
  int             e = 0;
  bit             model_live = 0;
  logic [CW-1:0]  m_credit;
  logic           m_resp_v, m_txr, m_ovf, m_rx_valid;
  logic [DW-1:0]  m_resp_d, m_rx_data;
  logic [CW+DW:0] m_pipe_in;
  int             m_drops;

  initial forever begin
    @(posedge clk);
    e++;
    if (rst) begin
      q.delete();
      m_credit = '0; m_resp_v = 1'b0; m_resp_d = '0; m_txr = 1'b0;
      m_ovf = 1'b0; m_drops = 0; m_pipe_in = '0;
      m_rx_valid = 1'b0; m_rx_data = '0;
    end else begin
      logic [CW+DW:0] pin_new;
      bit do_deq, was_full, txacc;
      ent_t en;
      pin_new  = {m_credit, m_resp_v, m_resp_d};
      do_deq   = m_rx_valid && rx_ready;
      was_full = (q.size() == DEPTH);
      if (do_deq) begin
        void'(q.pop_front());
        m_credit = m_credit + 3'd1;
      end
      if (pipe_out[DW]) begin
        if (!was_full || do_deq) begin
          en.d = pipe_out[DW-1:0];
          en.t = e;
          q.push_back(en);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
      txacc    = tx_valid && m_txr;
      m_resp_v = txacc;
      m_resp_d = txacc ? tx_data : '0;
      m_txr    = 1'b1;
      m_pipe_in = pin_new;
      m_rx_valid = (q.size() > 0) && (q[0].t < e);
      if (m_rx_valid) m_rx_data = q[0].d;
    end
    model_live = 1;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      chk("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
      if (m_rx_valid) chk("rx_data", 32'(rx_data), 32'(m_rx_data));
      chk("pipe_in", 32'(pipe_in), 32'(m_pipe_in));
      chk("tx_ready", 32'(tx_ready), 32'(m_txr));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SCEMI_RS_ADAPTER_DROP_COUNT_EN
      chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pipe_out = 9'h1FF; rx_ready = 1'b0; tx_valid = 1'b0;
    repeat (3) begin
      step();
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_pipe_in", 32'(pipe_in), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    end
    rst = 1'b0; pipe_out = '0;
    step();
    chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("post_rst_rx_valid", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_seq [4];

    // Reset with an all-ones host word held
    do_reset();

    // Single word
    rx_ready = 1'b1; pipe_out = 9'h1A5;
    step();
    pipe_out = '0;
    chk("single_no_bypass", 32'(rx_valid), 32'd0);
    step();
    chk("single_rx_valid", 32'(rx_valid), 32'd1);
    chk("single_rx_data", 32'(rx_data), 32'hA5);
    step();
    chk("single_drained", 32'(rx_valid), 32'd0);
    chk("single_credit_lag", 32'(pipe_in[11:9]), 32'd0);
    step();
    chk("single_credit", 32'(pipe_in[11:9]), 32'd1);

    // Fill and overflow
    do_reset();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      pipe_out = {1'b1, 8'(i)};
      step();
    end
    pipe_out = '0;
    step();
    chk("fill_overflow", 32'(overflow), 32'd1);
`ifdef SCEMI_RS_ADAPTER_DROP_COUNT_EN
    chk("fill_drop_count", 32'(drop_count), 32'd1);
`endif
    rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(rx_valid), 32'd1);
      chk("drain_data", 32'(rx_data), 32'(i));
      step();
    end
    rx_ready = 1'b0;
    chk("drain_empty", 32'(rx_valid), 32'd0);
    step();
    chk("drain_credit", 32'(pipe_in[11:9]), 32'd4);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Full plus simultaneous dequeue and write
    do_reset();
    rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pipe_out = {1'b1, 8'(i)};
      step();
    end
    pipe_out = '0;
    step();
    rx_ready = 1'b1; pipe_out = 9'h110;
    step();
    pipe_out = '0;
    chk("simul_no_overflow", 32'(overflow), 32'd0);
    exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      chk("simul_valid", 32'(rx_valid), 32'd1);
      chk("simul_data", 32'(rx_data), 32'(exp_seq[i]));
      step();
    end
    rx_ready = 1'b0;
    chk("simul_empty", 32'(rx_valid), 32'd0);
    chk("simul_overflow_end", 32'(overflow), 32'd0);

    // Credit wrap: 9 dequeues from reset
    do_reset();
    rx_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pipe_out = {1'b1, 8'(8'h40 + i)};
      step();
    end
    pipe_out = '0;
    repeat (4) step();
    chk("credit_wrap", 32'(pipe_in[11:9]), 32'd1);
    rx_ready = 1'b0;

    // TX single
    tx_valid = 1'b1; tx_data = 8'h3C;
    step();
    tx_valid = 1'b0; tx_data = '0;
    chk("tx_lag", 32'(pipe_in[8]), 32'd0);
    step();
    chk("tx_resp_valid", 32'(pipe_in[8]), 32'd1);
    chk("tx_resp_data", 32'(pipe_in[7:0]), 32'h3C);
    step();
    chk("tx_resp_clear", 32'(pipe_in[8]), 32'd0);

    // TX back-to-back
    tx_valid = 1'b1; tx_data = 8'h11;
    step();
    tx_data = 8'h22;
    step();
    tx_valid = 1'b0; tx_data = '0;
    chk("b2b_first", 32'(pipe_in[8:0]), 32'h111);
    step();
    chk("b2b_second", 32'(pipe_in[8:0]), 32'h122);
    step();
    chk("b2b_idle", 32'(pipe_in[8]), 32'd0);

    // Mid-operation reset discards queued words
    rx_ready = 1'b0;
    pipe_out = 9'h177;
    step();
    step();
    do_reset();
    chk("midrst_empty", 32'(rx_valid), 32'd0);
    repeat (2) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/scemi_pipe_rs_adapter.md
# scemi_pipe_rs_adapter

Synthesizable stream adapter between a SceMi register-style pipe proxy and DUT logic. It sits directly downstream of the proxy's per-cycle output word and upstream of its per-cycle input word. It turns the free-running, unflow-controlled proxy word into a buffered valid/ready receive stream, and packs DUT responses plus a flow-control credit count into the word the proxy samples every cycle.

## Interface
Parameters:
- DATA_W, 32, payload width in bits, both directions.
- DEPTH, 8, receive FIFO entries; must be a power of 2, at least 2.
- CREDIT_W, $clog2(DEPTH)+1, width of the wrapping credit counter; derived, not overridden.

Ports:
- CLK  in  1  sole clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- PIPE_OUT  in  DATA_W+1  word from proxy; [DATA_W] valid flag, [DATA_W-1:0] payload.
- PIPE_IN  out  CREDIT_W+1+DATA_W  word to proxy; {credit, resp_valid, resp_data}.
- RX_DATA  out  DATA_W  head of receive FIFO.
- RX_VALID  out  1  RX_DATA is valid.
- RX_READY  in  1  DUT accepts RX_DATA.
- TX_DATA  in  DATA_W  response payload.
- TX_VALID  in  1  response offered.
- TX_READY  out  1  response accepted when high with TX_VALID.
- OVERFLOW  out  1  sticky: a valid host word was dropped.

## Operation
- Receive: on each posedge where PIPE_OUT[DATA_W]=1, the payload is written to the FIFO if it is not full, or if it is full and a dequeue occurs in the same cycle. Otherwise the payload is dropped and OVERFLOW is set; it stays set until RST.
- Dequeue occurs on RX_VALID && RX_READY. FIFO order is strict.
- Credit: a CREDIT_W-bit counter increments on every dequeue and wraps modulo 2^CREDIT_W. It is presented in PIPE_IN[top CREDIT_W bits]. The host keeps in flight at most DEPTH minus the difference of successive samples, so missed samples lose nothing.
- Transmit: TX_READY is registered. It is 0 in the RST cycle and 1 from the first cycle after RST deasserts. An accepted TX loads the response register: resp_valid=1 and resp_data=TX_DATA for exactly one cycle, then resp_valid=0 unless a new TX is accepted. Back-to-back transfers give consecutive valid cycles.
- Reset mid-operation: FIFO contents are discarded, and the credit counter, OVERFLOW and the response register are cleared. The host resynchronises its credit baseline on its own reset.

## Timing
- Reset values: RX_VALID=0, RX_DATA=0, PIPE_IN=0, TX_READY=0, OVERFLOW=0.
- RX latency: a PIPE_OUT word valid at edge N gives RX_VALID=1 after edge N+1 when the FIFO was empty. There is no fall-through bypass.
- Credit latency: a dequeue at edge N is reflected in PIPE_IN after edge N+1.
- TX latency: acceptance at edge N puts the response on PIPE_IN after edge N+1.
- Full FIFO with a simultaneous dequeue and write: both take effect, count is unchanged, and no overflow is flagged.
- Empty FIFO: RX_READY is ignored and the credit counter does not change.
- PIPE_IN is fully registered. The proxy samples it mid-cycle, so no combinational path exists from inputs to PIPE_IN.

## Configuration
- SCEMI_RS_ADAPTER_DROP_COUNT_EN defined:
  - Adds port DROP_COUNT  out  16, a saturating count of dropped words, reset to 0.
  - The counter holds at 16'hFFFF once reached.
  - OVERFLOW behaviour is unchanged.
- Undefined: the port and counter are absent.

## Structure
- Package scemi_rs_adapter_pkg holds:
  - the PIPE_IN/PIPE_OUT field offset constants, as functions of DATA_W and CREDIT_W;
  - the credit-width function;
  - the DROP_COUNT width constant (16).
- Sub-module scemi_rs_fifo: synchronous FIFO with registered outputs.
  - Ports: enq, deq, full, empty, data.
  - Sync active-high reset.
  - Supports enq and deq in the same cycle when full.
- Top level holds the credit counter, overflow flag, response register, TX_READY register and the optional drop counter.

## Test plan
DATA_W=8, DEPTH=4, CREDIT_W=3 throughout.
- Reset: RST high 3 cycles with PIPE_OUT=9'h1FF, then deassert → no FIFO write; RX_VALID=0, PIPE_IN=0, OVERFLOW=0 throughout reset; TX_READY=1 one cycle after deassert.
- Single word: PIPE_OUT=9'h1A5 at edge 5, RX_READY=1 → RX_VALID=1, RX_DATA=8'hA5 after edge 6; dequeue at edge 7; credit=1 after edge 8.
- Fill/overflow: RX_READY=0, write 8'h01–8'h04 then 8'h05 → 8'h05 dropped, OVERFLOW=1 and remains 1; drain yields 01,02,03,04; credit=4; DROP_COUNT=1 when the macro is defined.
- Full plus simultaneous: FIFO full, RX_READY=1 and PIPE_OUT=9'h110 on the same edge → 8'h10 accepted as the new tail, OVERFLOW stays 0.
- Credit wrap: 9 dequeues from reset → credit field reads 3'd1.
- TX: TX_VALID=1, TX_DATA=8'h3C at edge N → PIPE_IN resp_valid=1, resp_data=8'h3C after N+1, resp_valid=0 after N+2; back-to-back 8'h11, 8'h22 → consecutive valid cycles in order.
